fifo_dut: RTL and testbench
===========================

Name: fifo_dut

Overview:
- Memory-mapped circular queue that acts as the device-under-test behind the board test unit.
- Consumes the test unit's address, write data and single-cycle write strobe; returns a registered read word for the seven-segment display.
- Exercises enqueue/dequeue, full/empty detection, pointer wrap-around and sticky error flags.

Parameters:
DEPTH, 8, number of 32-bit entries; power of two, 2..16
DW, 32, data width
AW, 16, address width

Ports:
clk  in  1  system clock (100 MHz)
rstn  in  1  asynchronous active-low reset
addr  in  AW  register/slot address from test unit
wdata  in  DW  write data from test unit
we  in  1  write strobe; one clk cycle per button press
rdata  out  DW  registered read data to test unit display
full  out  1  queue full (count == DEPTH)
empty  out  1  queue empty (count == 0)
count  out  5  number of valid entries, 0..DEPTH

Behaviour:
- Reset: clk, rstn (async, active-low). While rstn=0:
  - head=0, tail=0, count=0
  - all mem slots=0, pop_r=0, ovf=0, udf=0
  - rdata=0, empty=1, full=0
- Address map:
  - 0x0000..DEPTH-1: raw storage slots; read-only, writes ignored.
  - 0x0010: status word (read-only): {16'h0, ovf[15], udf[14], full[13], empty[12], count[11:8] (low 4 bits), head[7:4], tail[3:0]}; unused pointer bits are 0.
  - 0x0020: PUSH (write-only).
  - 0x0021: POP (write-only).
  - 0x0022: last popped word pop_r (read-only).
  - 0x0023: CLR_ERR (write-only).
  - Any other address: reads 0, writes ignored.
- At most one operation per cycle: only the single addr is decoded, so simultaneous push and pop cannot occur.
- PUSH (we & addr==0x0020):
  - If !full: mem[tail]<=wdata, tail<=tail+1 mod DEPTH, count<=count+1.
  - If full: state unchanged, ovf<=1 (sticky).
- POP (we & addr==0x0021):
  - If !empty: pop_r<=mem[head], mem[head]<=0, head<=head+1 mod DEPTH, count<=count-1.
  - If empty: pop_r unchanged, udf<=1 (sticky).
- CLR_ERR (we & addr==0x0023): ovf<=0, udf<=0. No other state changes.
- Pointers: log2(DEPTH) bits, wrap naturally. count is a separate counter, so full and empty are unambiguous when head==tail.
- full and empty are combinational from count and reflect the updated state in the cycle after the edge.
- Read path:
  - rdata registered every clk, 1-cycle latency.
  - rdata(n+1) = decode(addr(n), state before edge n's update).
  - Consequence: a value written at edge n is visible via rdata at n+2 when addr is held.
- we held high for multiple cycles performs one operation per cycle. No internal edge detection; the upstream unit supplies pulses.
- Reset mid-operation: asynchronous clear wins. No partial push or pop survives.

Optional Feature:
- Macro: FIFO_PEEK_EN.
- Defined: address 0x0024 reads mem[head] without popping (0 when empty). Status bit [16] = 1 indicates peek is present.
- Undefined: 0x0024 reads 0 like any unmapped address; status bit [16] = 0. No extra logic is generated.

Test Plan:
- Reset, then read 0x0010 -> rdata=0x00001000 (empty=1, all pointers 0). Outputs empty=1, full=0, count=0.
- Push 0x11111111, 0x22222222, then pop at 0x0021, then read 0x0022 -> rdata=0x11111111. Status reads count=1, head=1, tail=2. Slot 0 reads 0.
- Push 8 values 0xA0..0xA7 (DEPTH=8) -> full=1, status=0x00002800 | head 0 | tail 0. A ninth push of 0xFF sets ovf (status bit15=1); slot 0 still reads 0xA0.
- With the queue empty, pop -> udf=1, pop_r unchanged. Write 0x0023 -> status bits 15:14 = 0.
- Wrap-around:
  - Step 1: push 6, pop 6, push 4 (0xB0..0xB3).
  - Step 2: tail=2, head=6, count=4. Slots 6,7,0,1 hold 0xB0..0xB3.
  - Step 3: four pops return 0xB0..0xB3 in order, then empty=1.
- Assert rstn low mid-sequence with count=5 -> next cycle count=0, rdata=0, empty=1, pop_r=0.
- FIFO_PEEK_EN build: after pushing 0xC0, read 0x0024 -> rdata=0xC0 and count unchanged.

Source files
------------

// File: rtl/fifo_dut.sv
// Memory-mapped circular queue behind the board test unit: push/pop/clear via write strobes,
// registered read-back of slots, status and last popped word. Optional peek port: FIFO_PEEK_EN.
module fifo_dut #(
    parameter int DEPTH = 8,
    parameter int DW    = 32,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic          we,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [4:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [AW-1:0] ADDR_STATUS = AW'(16'h0010);
    localparam logic [AW-1:0] ADDR_PUSH   = AW'(16'h0020);
    localparam logic [AW-1:0] ADDR_POP    = AW'(16'h0021);
    localparam logic [AW-1:0] ADDR_POPR   = AW'(16'h0022);
    localparam logic [AW-1:0] ADDR_CLR    = AW'(16'h0023);
`ifdef FIFO_PEEK_EN
    localparam logic [AW-1:0] ADDR_PEEK   = AW'(16'h0024);
`endif
    localparam logic [AW-1:0] ADDR_SLOTS  = AW'(DEPTH);
    localparam logic [4:0]    DEPTH_CNT   = 5'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [4:0]    count_q, count_d;
    logic [DW-1:0] popR_q, popR_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          doPush;
    logic          doPop;
    logic [31:0]   statusWord;

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == 5'd0);
    assign count = count_q;
    assign rdata = rdata_q;

    // Only one address is decoded per cycle, so push and pop are mutually exclusive.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        popR_d  = popR_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        doPush  = 1'b0;
        doPop   = 1'b0;
        if (we) begin
            if (addr == ADDR_PUSH) begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    doPush  = 1'b1;
                    tail_d  = tail_q + PW'(1);
                    count_d = count_q + 5'd1;
                end
            end else if (addr == ADDR_POP) begin
                if (empty) begin
                    udf_d = 1'b1;
                end else begin
                    doPop   = 1'b1;
                    popR_d  = mem_q[head_q];
                    head_d  = head_q + PW'(1);
                    count_d = count_q - 5'd1;
                end
            end else if (addr == ADDR_CLR) begin
                ovf_d = 1'b0;
                udf_d = 1'b0;
            end
        end
    end

    always_comb begin
        statusWord        = '0;
        statusWord[15]    = ovf_q;
        statusWord[14]    = udf_q;
        statusWord[13]    = full;
        statusWord[12]    = empty;
        statusWord[11:8]  = count_q[3:0];
        statusWord[7:4]   = 4'(head_q);
        statusWord[3:0]   = 4'(tail_q);
`ifdef FIFO_PEEK_EN
        statusWord[16]    = 1'b1;
`endif
    end

    // Read decode sees the state from before this edge's update, giving one cycle of latency.
    always_comb begin
        rdata_d = '0;
        if (addr < ADDR_SLOTS) begin
            rdata_d = mem_q[addr[PW-1:0]];
        end else if (addr == ADDR_STATUS) begin
            rdata_d = DW'(statusWord);
        end else if (addr == ADDR_POPR) begin
            rdata_d = popR_q;
`ifdef FIFO_PEEK_EN
        end else if (addr == ADDR_PEEK) begin
            rdata_d = empty ? '0 : mem_q[head_q];
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            popR_q  <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            popR_q  <= popR_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            rdata_q <= rdata_d;
        end
    end

    // Popped slots are zeroed so raw slot reads show only live entries.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (doPush) begin
            mem_q[tail_q] <= wdata;
        end else if (doPop) begin
            mem_q[head_q] <= '0;
        end
    end

endmodule

// File: tb/tb_fifo_dut.sv
// Self-checking bench for fifo_dut: directed scenarios plus randomized traffic against
// a queue-level reference model. Define FIFO_PEEK_EN on both to check the peek port.
module tb_fifo_dut;

   localparam int DEPTH = 8;

   logic        clk;
   logic        rstn;
   logic [15:0] addr;
   logic [31:0] wdata;
   logic        we;
   logic [31:0] rdata;
   logic        full;
   logic        empty;
   logic [4:0]  count;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: plain array with modulo pointer arithmetic.
   logic [31:0] mMem [DEPTH];
   int          mHead, mTail, mCount;
   logic [31:0] mPop;
   logic        mOvf, mUdf;

   fifo_dut #(.DEPTH(DEPTH), .DW(32), .AW(16)) dut (
      .clk   (clk),
      .rstn  (rstn),
      .addr  (addr),
      .wdata (wdata),
      .we    (we),
      .rdata (rdata),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model reset: everything cleared
   task automatic modelReset();
      for (int i = 0; i < DEPTH; i++) mMem[i] = '0;
      mHead = 0; mTail = 0; mCount = 0;
      mPop = '0; mOvf = 1'b0; mUdf = 1'b0;
   endtask

   // Model effect of one write strobe
   task automatic modelApply(input logic [15:0] a, input logic [31:0] d);
      if (a == 16'h0020) begin
         if (mCount == DEPTH) mOvf = 1'b1;
         else begin
            mMem[mTail] = d;
            mTail = (mTail + 1) % DEPTH;
            mCount++;
         end
      end else if (a == 16'h0021) begin
         if (mCount == 0) mUdf = 1'b1;
         else begin
            mPop = mMem[mHead];
            mMem[mHead] = '0;
            mHead = (mHead + 1) % DEPTH;
            mCount--;
         end
      end else if (a == 16'h0023) begin
         mOvf = 1'b0;
         mUdf = 1'b0;
      end
   endtask

   // Model read decode from current state
   function automatic logic [31:0] modelRead(input logic [15:0] a);
      logic [31:0] v;
      v = '0;
      if (a < 16'(DEPTH)) v = mMem[a];
      else if (a == 16'h0010) begin
         v = (32'(mOvf) << 15) | (32'(mUdf) << 14) | (32'(mCount == DEPTH) << 13)
           | (32'(mCount == 0) << 12) | (32'(mCount % 16) << 8)
           | (32'(mHead) << 4) | 32'(mTail);
`ifdef FIFO_PEEK_EN
         v = v | 32'h0001_0000;
`endif
      end else if (a == 16'h0022) v = mPop;
`ifdef FIFO_PEEK_EN
      else if (a == 16'h0024) v = (mCount == 0) ? 32'h0 : mMem[mHead];
`endif
      return v;
   endfunction

   // One clock cycle with the given bus values; model tracks the edge
   task automatic applyStimulus(input logic [15:0] a, input logic [31:0] d, input logic w);
      @(negedge clk);
      addr = a; wdata = d; we = w;
      @(posedge clk);
      if (w) modelApply(a, d);
      #1;
      we = 1'b0;
   endtask

   // Issue a read cycle; returns observed rdata and the model's expectation
   task automatic readAddr(input logic [15:0] a, output logic [31:0] got, output logic [31:0] exp);
      exp = modelRead(a);
      applyStimulus(a, 32'h0, 1'b0);
      got = rdata;
   endtask

   task automatic doReset();
      @(negedge clk);
      rstn = 1'b0;
      modelReset();
      @(negedge clk);
      rstn = 1'b1;
   endtask

   // Reset values of the outputs, then the status word
   task automatic test_reset();
      logic [31:0] got, exp;
      rstn = 1'b0; addr = '0; wdata = '0; we = 1'b0;
      modelReset();
      #12;
      vectors++;
      if (rdata !== 32'h0 || empty !== 1'b1 || full !== 1'b0 || count !== 5'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: got rdata=%h empty=%b full=%b count=%0d, want 0/1/0/0", rdata, empty, full, count);
      end
      @(negedge clk);
      rstn = 1'b1;
      readAddr(16'h0010, got, exp);
      vectors++;
      if (got !== exp || (got & 32'h0000_FFFF) !== 32'h0000_1000) begin
         miscompares++;
         $display("[TB] FAIL reset_status: got %h want %h", got, exp);
      end
   endtask

   // Two pushes, one pop, last-popped and status read-back
   task automatic test_push_pop();
      logic [31:0] got, exp;
      applyStimulus(16'h0020, 32'h1111_1111, 1'b1);
      applyStimulus(16'h0020, 32'h2222_2222, 1'b1);
      applyStimulus(16'h0021, 32'h0, 1'b1);
      readAddr(16'h0022, got, exp);
      vectors++;
      if (got !== 32'h1111_1111) begin
         miscompares++;
         $display("[TB] FAIL pop_value: got %h want %h", got, 32'h1111_1111);
      end
      readAddr(16'h0010, got, exp);
      vectors++;
      if (got !== exp || got[11:0] !== 12'h112) begin
         miscompares++;
         $display("[TB] FAIL pushpop_status: got %h want %h", got, exp);
      end
      readAddr(16'h0000, got, exp);
      vectors++;
      if (got !== 32'h0) begin
         miscompares++;
         $display("[TB] FAIL popped_slot_zero: got %h want 0", got);
      end
   endtask

   // Fill to DEPTH, then overflow
   task automatic test_full_overflow();
      logic [31:0] got, exp;
      doReset();
      for (int i = 0; i < DEPTH; i++) applyStimulus(16'h0020, 32'hA0 + 32'(i), 1'b1);
      vectors++;
      if (full !== 1'b1 || empty !== 1'b0 || count !== 5'd8) begin
         miscompares++;
         $display("[TB] FAIL full_flags: got full=%b empty=%b count=%0d want 1/0/8", full, empty, count);
      end
      readAddr(16'h0010, got, exp);
      vectors++;
      if (got !== exp || got[15:0] !== 16'h2800) begin
         miscompares++;
         $display("[TB] FAIL full_status: got %h want %h", got, exp);
      end
      applyStimulus(16'h0020, 32'hFF, 1'b1);
      readAddr(16'h0010, got, exp);
      vectors++;
      if (got !== exp || got[15] !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL ovf_status: got %h want %h", got, exp);
      end
      readAddr(16'h0000, got, exp);
      vectors++;
      if (got !== 32'hA0) begin
         miscompares++;
         $display("[TB] FAIL ovf_slot0: got %h want %h", got, 32'hA0);
      end
   endtask

   // Drain, pop once more for underflow, then clear errors
   task automatic test_underflow_clear();
      logic [31:0] got, exp;
      for (int i = 0; i < DEPTH; i++) applyStimulus(16'h0021, 32'h0, 1'b1);
      applyStimulus(16'h0021, 32'h0, 1'b1);
      readAddr(16'h0022, got, exp);
      vectors++;
      if (got !== 32'hA7) begin
         miscompares++;
         $display("[TB] FAIL udf_popr_kept: got %h want %h", got, 32'hA7);
      end
      readAddr(16'h0010, got, exp);
      vectors++;
      if (got !== exp || got[15:14] !== 2'b11) begin
         miscompares++;
         $display("[TB] FAIL udf_status: got %h want %h", got, exp);
      end
      applyStimulus(16'h0023, 32'h0, 1'b1);
      readAddr(16'h0010, got, exp);
      vectors++;
      if (got !== exp || got[15:14] !== 2'b00) begin
         miscompares++;
         $display("[TB] FAIL clr_err_status: got %h want %h", got, exp);
      end
   endtask

   // Pointer wrap-around across the end of storage
   task automatic test_wrap();
      logic [31:0] got, exp;
      logic [15:0] slots [4];
      slots[0] = 16'd6; slots[1] = 16'd7; slots[2] = 16'd0; slots[3] = 16'd1;
      doReset();
      for (int i = 0; i < 6; i++) applyStimulus(16'h0020, 32'h50 + 32'(i), 1'b1);
      for (int i = 0; i < 6; i++) applyStimulus(16'h0021, 32'h0, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus(16'h0020, 32'hB0 + 32'(i), 1'b1);
      readAddr(16'h0010, got, exp);
      vectors++;
      if (got !== exp || got[11:0] !== 12'h462) begin
         miscompares++;
         $display("[TB] FAIL wrap_status: got %h want %h", got, exp);
      end
      for (int i = 0; i < 4; i++) begin
         readAddr(slots[i], got, exp);
         vectors++;
         if (got !== 32'hB0 + 32'(i)) begin
            miscompares++;
            $display("[TB] FAIL wrap_slot%0d: got %h want %h", slots[i], got, 32'hB0 + 32'(i));
         end
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(16'h0021, 32'h0, 1'b1);
         readAddr(16'h0022, got, exp);
         vectors++;
         if (got !== 32'hB0 + 32'(i)) begin
            miscompares++;
            $display("[TB] FAIL wrap_pop%0d: got %h want %h", i, got, 32'hB0 + 32'(i));
         end
      end
      vectors++;
      if (empty !== 1'b1 || count !== 5'd0) begin
         miscompares++;
         $display("[TB] FAIL wrap_empty: got empty=%b count=%0d want 1/0", empty, count);
      end
   endtask

   // Randomized traffic: every cycle checks rdata latency and flags against the model
   task automatic test_random();
      logic [15:0] addrTable [12];
      logic [15:0] a;
      logic [31:0] d, exp;
      logic        w;
      addrTable[0] = 16'h0020; addrTable[1] = 16'h0020; addrTable[2] = 16'h0021;
      addrTable[3] = 16'h0021; addrTable[4] = 16'h0022; addrTable[5] = 16'h0010;
      addrTable[6] = 16'h0023; addrTable[7] = 16'h0024; addrTable[8] = 16'h0011;
      addrTable[9] = 16'h0008; addrTable[10] = 16'h8020; addrTable[11] = 16'h0000;
      for (int n = 0; n < 400; n++) begin
         a = addrTable[$urandom_range(0, 11)];
         if (a == 16'h0000) a = 16'($urandom_range(0, DEPTH - 1));
         d = $urandom;
         w = 1'($urandom_range(0, 3) != 0);
         exp = modelRead(a);
         applyStimulus(a, d, w);
         vectors++;
         if (rdata !== exp || count !== 5'(mCount) || full !== (mCount == DEPTH) || empty !== (mCount == 0)) begin
            miscompares++;
            $display("[TB] FAIL random_%0d a=%h: got rdata=%h count=%0d full=%b empty=%b want %h/%0d/%b/%b",
                     n, a, rdata, count, full, empty, exp, mCount, mCount == DEPTH, mCount == 0);
         end
      end
   endtask

   // Asynchronous reset in the middle of a cycle with five entries queued
   task automatic test_reset_midway();
      logic [31:0] got, exp;
      doReset();
      for (int i = 0; i < 5; i++) applyStimulus(16'h0020, 32'hD0 + 32'(i), 1'b1);
      applyStimulus(16'h0021, 32'h0, 1'b1);
      applyStimulus(16'h0020, 32'hD5, 1'b1);
      vectors++;
      if (count !== 5'd5) begin
         miscompares++;
         $display("[TB] FAIL pre_reset_count: got %0d want 5", count);
      end
      @(negedge clk);
      addr = 16'h0022; we = 1'b1; addr = 16'h0020; wdata = 32'hEE;
      #2;
      rstn = 1'b0;
      modelReset();
      #1;
      vectors++;
      if (count !== 5'd0 || rdata !== 32'h0 || empty !== 1'b1 || full !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL midreset_outputs: got count=%0d rdata=%h empty=%b full=%b want 0/0/1/0", count, rdata, empty, full);
      end
      @(negedge clk);
      we = 1'b0;
      rstn = 1'b1;
      readAddr(16'h0022, got, exp);
      vectors++;
      if (got !== 32'h0) begin
         miscompares++;
         $display("[TB] FAIL midreset_popr: got %h want 0", got);
      end
      readAddr(16'h0000, got, exp);
      vectors++;
      if (got !== 32'h0) begin
         miscompares++;
         $display("[TB] FAIL midreset_slot0: got %h want 0", got);
      end
   endtask

   // Peek address: live head word with the feature, plain zero without
   task automatic test_peek();
      logic [31:0] got, exp;
      doReset();
      applyStimulus(16'h0020, 32'hC0, 1'b1);
      readAddr(16'h0024, got, exp);
      vectors++;
`ifdef FIFO_PEEK_EN
      if (got !== 32'hC0 || count !== 5'd1) begin
         miscompares++;
         $display("[TB] FAIL peek_read: got %h count=%0d want %h count=1", got, count, 32'hC0);
      end
`else
      if (got !== 32'h0 || count !== 5'd1) begin
         miscompares++;
         $display("[TB] FAIL peek_absent: got %h count=%0d want 0 count=1", got, count);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_push_pop();
      test_full_overflow();
      test_underflow_clear();
      test_wrap();
      test_peek();
      doReset();
      test_random();
      test_reset_midway();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
